// File: rtl/lv_pwm_code_decode.sv
// ---------------------------------------------------------------------------
// lv_pwm_code_decode
//
// Low-voltage-side decoder for the pulse-coded, active-low interrupt line
// arriving from the HV die through the isolation receiver.
//
// The raw line is synchronised, debounced, and every accepted level change
// counts as one edge. A frame opens on its first edge and closes once the
// line has been quiet for GAP_CYC cycles. A closed frame reports its edge
// count as a code. Two dedicated codes set or clear a decoded interrupt
// level. A frame with more than MAX_EDGE edges is reported as an error.
//
// Ports:
//   i_clk            clock
//   i_rst_n          asynchronous active-low reset
//   i_pwm_n          asynchronous pulse-coded line, idle high
//   i_en             synchronous decode enable
//   o_pwm_gwave      combinational copy of i_pwm_n for observation
//   o_filt           debounced line level
//   o_busy           a frame is open
//   o_code_vld       1-cycle pulse: frame closed with a legal count
//   o_code           edge count of the last valid frame, held between pulses
//   o_code_err       1-cycle pulse: frame exceeded MAX_EDGE edges
//   o_intb_set_pulse valid code equal to INTB_SET_CODE
//   o_intb_clr_pulse valid code equal to INTB_CLR_CODE
//   o_intb_n         decoded interrupt, active low
// ---------------------------------------------------------------------------
module lv_pwm_code_decode #(
    parameter int  SYNC_STG      = 2,
    parameter int  DEB_CYC       = 4,
    parameter int  GAP_CYC       = 16,
    parameter int  MAX_EDGE      = 7,
    parameter int  INTB_SET_CODE = 2,
    parameter int  INTB_CLR_CODE = 4,
    localparam int CODE_W        = $clog2(MAX_EDGE + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pwm_n,
    input  logic              i_en,
    output logic              o_pwm_gwave,
    output logic              o_filt,
    output logic              o_busy,
    output logic              o_code_vld,
    output logic [CODE_W-1:0] o_code,
    output logic              o_code_err,
    output logic              o_intb_set_pulse,
    output logic              o_intb_clr_pulse,
    output logic              o_intb_n
);

    localparam int GAP_W = $clog2(GAP_CYC);
    localparam int DEB_W = $clog2(DEB_CYC + 1);

    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [CODE_W-1:0] EDGE_MAX = CODE_W'(MAX_EDGE);
    localparam logic [CODE_W-1:0] SET_C    = CODE_W'(INTB_SET_CODE);
    localparam logic [CODE_W-1:0] CLR_C    = CODE_W'(INTB_CLR_CODE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        OVF   = 2'd2
    } state_t;

    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                s;

    logic                filt_q, filt_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic                edge_q, edge_d;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                code_vld_q, code_vld_d;
    logic                code_err_q, code_err_d;
    logic                intb_n_q, intb_n_d;

    logic                timeout;
    logic                set_pulse;
    logic                clr_pulse;

    // Synchroniser: shift the raw line in at bit 0, use the oldest bit.
    assign sync_d = {sync_q[SYNC_STG-2:0], i_pwm_n};
    assign s      = sync_q[SYNC_STG-1];

    // Debounce: a new level must be seen DEB_CYC cycles in a row. The edge
    // pulse is registered together with the o_filt update.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = deb_cnt_q;
        edge_d    = 1'b0;
        if (s == filt_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            filt_d    = s;
            deb_cnt_d = '0;
            edge_d    = 1'b1;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // An edge in the same cycle as the gap expiring keeps the frame open.
    assign timeout = (gap_cnt_q == GAP_LAST) && !edge_q;

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        code_d     = code_q;
        code_vld_d = 1'b0;
        code_err_d = 1'b0;

        if (edge_q) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q != GAP_LAST) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (edge_q) begin
                    state_d    = COUNT;
                    edge_cnt_d = CODE_W'(1);
                end
            end
            COUNT: begin
                if (edge_q) begin
                    // edge_cnt stays at MAX_EDGE in OVF; it never wraps.
                    if (edge_cnt_q == EDGE_MAX) begin
                        state_d = OVF;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end else if (timeout) begin
                    code_vld_d = 1'b1;
                    code_d     = edge_cnt_q;
                    edge_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            OVF: begin
                if (timeout) begin
                    code_err_d = 1'b1;
                    edge_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase

        // Disabled: abandon any open frame; edges seen now are lost.
        if (!i_en) begin
            state_d    = IDLE;
            edge_cnt_d = '0;
            gap_cnt_d  = '0;
            code_d     = code_q;
            code_vld_d = 1'b0;
            code_err_d = 1'b0;
        end
    end

    assign set_pulse = code_vld_q && (code_q == SET_C);
    assign clr_pulse = code_vld_q && (code_q == CLR_C);

    always_comb begin
        intb_n_d = intb_n_q;
        if (set_pulse) begin
            intb_n_d = 1'b0;
        end else if (clr_pulse) begin
            intb_n_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q     <= '1;
            filt_q     <= 1'b1;
            deb_cnt_q  <= '0;
            edge_q     <= 1'b0;
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            gap_cnt_q  <= '0;
            code_q     <= '0;
            code_vld_q <= 1'b0;
            code_err_q <= 1'b0;
            intb_n_q   <= 1'b1;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            deb_cnt_q  <= deb_cnt_d;
            edge_q     <= edge_d;
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            code_q     <= code_d;
            code_vld_q <= code_vld_d;
            code_err_q <= code_err_d;
            intb_n_q   <= intb_n_d;
        end
    end

    assign o_pwm_gwave      = i_pwm_n;
    assign o_filt           = filt_q;
    assign o_busy           = (state_q != IDLE);
    assign o_code_vld       = code_vld_q;
    assign o_code           = code_q;
    assign o_code_err       = code_err_q;
    assign o_intb_set_pulse = set_pulse;
    assign o_intb_clr_pulse = clr_pulse;
    assign o_intb_n         = intb_n_q;

endmodule

// File: tb/tb_lv_pwm_code_decode.sv
// ---------------------------------------------------------------------------
// tb_lv_pwm_code_decode
//
// Scoreboard bench. Stimulus toggles the raw line a known number of times
// per frame and pushes the expected frame outcome (code or error, resulting
// interrupt level, time of last line change). A separate monitor pops one
// entry whenever the DUT pulses o_code_vld/o_code_err and compares.
// ---------------------------------------------------------------------------
module tb_lv_pwm_code_decode;

    localparam int SYNC_STG = 2;
    localparam int DEB_CYC  = 4;
    localparam int GAP_CYC  = 16;
    localparam int MAX_EDGE = 7;
    localparam int SET_C    = 2;
    localparam int CLR_C    = 4;
    localparam int CW       = $clog2(MAX_EDGE + 1);
    // line change -> sync -> debounce -> quiet gap -> registered pulse
    localparam int LAT      = SYNC_STG + DEB_CYC + GAP_CYC;
    localparam int QUIET    = LAT + 8;

    logic          i_clk   = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_pwm_n = 1'b1;
    logic          i_en    = 1'b0;
    logic          o_pwm_gwave;
    logic          o_filt;
    logic          o_busy;
    logic          o_code_vld;
    logic [CW-1:0] o_code;
    logic          o_code_err;
    logic          o_intb_set_pulse;
    logic          o_intb_clr_pulse;
    logic          o_intb_n;

    lv_pwm_code_decode dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_pwm_n          (i_pwm_n),
        .i_en             (i_en),
        .o_pwm_gwave      (o_pwm_gwave),
        .o_filt           (o_filt),
        .o_busy           (o_busy),
        .o_code_vld       (o_code_vld),
        .o_code           (o_code),
        .o_code_err       (o_code_err),
        .o_intb_set_pulse (o_intb_set_pulse),
        .o_intb_clr_pulse (o_intb_clr_pulse),
        .o_intb_n         (o_intb_n)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit err;
        int code;
        int intb;
        int t_chg;
    } exp_t;

    exp_t sb[$];

    // Reference state as implied by all frames issued so far.
    int mdl_code = 0;
    int mdl_intb = 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Emit n line toggles, spaced seg_lo..seg_hi cycles, then stay quiet.
    task automatic send_frame(input int n, input int seg_lo, input int seg_hi);
        exp_t e;
        int   t_last;
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            i_pwm_n = ~i_pwm_n;
            t_last  = cyc;
            if (i < n - 1) tick($urandom_range(seg_hi, seg_lo));
        end
        e.t_chg = t_last;
        if (n > MAX_EDGE) begin
            e.err  = 1'b1;
            e.code = mdl_code;
        end else begin
            e.err    = 1'b0;
            e.code   = n;
            mdl_code = n;
            if (n == SET_C) mdl_intb = 0;
            if (n == CLR_C) mdl_intb = 1;
        end
        e.intb = mdl_intb;
        sb.push_back(e);
        tick(QUIET);
    endtask

    task automatic settle(input string nm);
        @(negedge i_clk);
        chk({nm, " busy"}, int'(o_busy), 0);
        chk({nm, " drained"}, sb.size(), 0);
        chk({nm, " code hold"}, int'(o_code), mdl_code);
        chk({nm, " intb"}, int'(o_intb_n), mdl_intb);
        @(posedge i_clk);
        #1;
    endtask

    // Short pulse opposite to the idle level: must not be accepted.
    task automatic glitch(input int len);
        int lvl;
        lvl = int'(i_pwm_n);
        i_pwm_n = ~i_pwm_n;
        tick(len);
        i_pwm_n = ~i_pwm_n;
        repeat (12) begin
            @(negedge i_clk);
            chk("glitch filt", int'(o_filt), lvl);
            chk("glitch busy", int'(o_busy), 0);
        end
        tick(4);
    endtask

    // Monitor
    initial begin
        exp_t e;
        int   d;
        bit   intb_pend;
        int   intb_exp;
        intb_pend = 1'b0;
        intb_exp  = 1;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                intb_pend = 1'b0;
            end else begin
                if (intb_pend) begin
                    chk("intb_n after event", int'(o_intb_n), intb_exp);
                    intb_pend = 1'b0;
                end
                if (o_code_vld || o_code_err) begin
                    if (sb.size() == 0) begin
                        chk("unexpected vld/err", int'({o_code_vld, o_code_err}), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("err pulse", int'(o_code_err), int'(e.err));
                        chk("vld pulse", int'(o_code_vld), int'(!e.err));
                        chk("code", int'(o_code), e.code);
                        chk("set pulse", int'(o_intb_set_pulse), int'(!e.err && e.code == SET_C));
                        chk("clr pulse", int'(o_intb_clr_pulse), int'(!e.err && e.code == CLR_C));
                        d = cyc - e.t_chg;
                        checks++;
                        if (d < LAT || d > LAT + 1) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles expected %0d..%0d", d, LAT, LAT + 1);
                        end
                        intb_pend = 1'b1;
                        intb_exp  = e.intb;
                    end
                end else if (o_intb_set_pulse || o_intb_clr_pulse) begin
                    chk("stray set/clr", int'({o_intb_set_pulse, o_intb_clr_pulse}), 0);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit seen;
        tick(3);
        @(negedge i_clk);
        chk("rst filt", int'(o_filt), 1);
        chk("rst busy", int'(o_busy), 0);
        chk("rst code", int'(o_code), 0);
        chk("rst intb", int'(o_intb_n), 1);
        chk("rst vld/err", int'({o_code_vld, o_code_err}), 0);
        chk("gwave", int'(o_pwm_gwave), int'(i_pwm_n));
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_en    = 1'b1;
        tick(4);

        // One 8-cycle low pulse: SET
        send_frame(2, 8, 8);
        settle("set frame");

        // Two pulses: CLR, then SET again
        send_frame(4, 8, 8);
        settle("clr frame");
        send_frame(2, 8, 8);
        settle("set again");

        // Sub-debounce glitch
        glitch(DEB_CYC - 1);
        settle("glitch");

        // 8 edges: overflow error, code and intb hold
        send_frame(8, 8, 8);
        settle("overflow");

        // 3 edges: spare code, line left low
        send_frame(3, 8, 8);
        settle("spare 3");
        send_frame(1, 8, 8);
        settle("spare 1");

        // Disable after first edge of a 2-edge frame
        i_pwm_n = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge i_clk);
            if (o_busy) seen = 1'b1;
        end
        chk("busy after first edge", int'(o_busy), 1);
        @(posedge i_clk);
        #1;
        i_en = 1'b0;
        tick(2);
        @(negedge i_clk);
        chk("busy when disabled", int'(o_busy), 0);
        @(posedge i_clk);
        #1;
        i_pwm_n = 1'b1;
        tick(QUIET);
        i_en = 1'b1;
        tick(2);
        settle("enable drop");

        // Reset mid-frame
        i_pwm_n = 1'b0;
        tick(10);
        @(negedge i_clk);
        chk("busy mid-frame", int'(o_busy), 1);
        #1;
        i_pwm_n = 1'b1;
        i_rst_n = 1'b0;
        #2;
        chk("mid rst filt", int'(o_filt), 1);
        chk("mid rst busy", int'(o_busy), 0);
        chk("mid rst code", int'(o_code), 0);
        chk("mid rst intb", int'(o_intb_n), 1);
        chk("mid rst vld/err", int'({o_code_vld, o_code_err}), 0);
        mdl_code = 0;
        mdl_intb = 1;
        tick(3);
        i_rst_n = 1'b1;
        tick(3);
        send_frame(2, 8, 8);
        settle("after reset");

        // Randomised frames with occasional glitches
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(3, 0) == 0) glitch($urandom_range(DEB_CYC - 1, 1));
            send_frame($urandom_range(MAX_EDGE + 2, 1), DEB_CYC, GAP_CYC - 2);
            settle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
